// File: rtl/bgr_word_to_gray.sv
// Packed 24-bit BGR word stream to 8-bit gray samples: re-aligns 3 input words
// into 4 pixels and emits floor((B+G+R)/3) through a one-entry holding register.
module bgr_word_to_gray #(
    parameter int PIXELS_PER_FRAME = 518400,
    parameter int CNT_W            = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_dout,
    input  logic        in_empty,
    output logic        in_rd_en,
    output logic [7:0]  out_din,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH2B} phase_t;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS_PER_FRAME - 1);

    // Handshake: a sample transfers on every cycle out_wr_en=1; an input word
    // is consumed on every cycle in_rd_en=1 (show-ahead head word in_dout).
    phase_t           state_q, state_d;
    logic [23:0]      carry_q, carry_d;
    logic [7:0]       gray_q, gray_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        room;
    logic        load;
    logic [7:0]  pix_b, pix_g, pix_r;
    logic [9:0]  sum;
    logic [20:0] prod;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PH0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the phase only advances when a pixel is loaded.
    always_comb begin
        state_d = state_q;
        if (load) begin
            case (state_q)
                PH0:     state_d = PH1;
                PH1:     state_d = PH2;
                PH2:     state_d = PH2B;
                default: state_d = PH0;
            endcase
        end
    end

    // Output / datapath logic. Room depends only on valid_q and out_full,
    // keeping in_empty off the out_wr_en path.
    always_comb begin
        out_wr_en = valid_q & ~out_full;
        room      = ~valid_q | out_wr_en;
        in_rd_en  = (state_q != PH2B) & ~in_empty & room;
        load      = in_rd_en | ((state_q == PH2B) & room);
        carry_d   = carry_q;
        pix_b     = 8'd0;
        pix_g     = 8'd0;
        pix_r     = 8'd0;
        case (state_q)
            PH0: begin
                pix_b = in_dout[7:0];
                pix_g = in_dout[15:8];
                pix_r = in_dout[23:16];
                if (in_rd_en) carry_d[7:0] = in_dout[31:24];
            end
            PH1: begin
                pix_b = carry_q[7:0];
                pix_g = in_dout[7:0];
                pix_r = in_dout[15:8];
                if (in_rd_en) carry_d[15:0] = in_dout[31:16];
            end
            PH2: begin
                pix_b = carry_q[7:0];
                pix_g = carry_q[15:8];
                pix_r = in_dout[7:0];
                if (in_rd_en) carry_d = in_dout[31:8];
            end
            default: begin
                pix_b = carry_q[7:0];
                pix_g = carry_q[15:8];
                pix_r = carry_q[23:16];
            end
        endcase
        // (sum*683)>>11 equals floor(sum/3) for every sum in 0..765.
        sum    = {2'b00, pix_b} + {2'b00, pix_g} + {2'b00, pix_r};
        prod   = 21'(sum) * 21'd683;
        gray_d = load ? prod[18:11] : gray_q;
        if (load)           valid_d = 1'b1;
        else if (out_wr_en) valid_d = 1'b0;
        else                valid_d = valid_q;
        frame_done = out_wr_en & (cnt_q == LAST_PIX);
        if (frame_done)     cnt_d = '0;
        else if (out_wr_en) cnt_d = cnt_q + 1'b1;
        else                cnt_d = cnt_q;
        out_din   = gray_q;
        dbg_state = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            carry_q <= carry_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
